// File: rtl/mul_long_unit.sv
// mul_long_unit: iterative shift-add long multiplier (MUL/MLA/UMULL/SMULL/UMLAL/SMLAL).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               request, honoured only in IDLE; a, b, acc_hi, acc_lo,
//                       op_signed and op_acc are captured with it
//   op_signed           1 = signed operands, 0 = unsigned
//   op_acc              1 = add {acc_hi, acc_lo} to the product
//   busy                high in every state except IDLE
//   done                one-cycle pulse, result valid in the same cycle
//   result_hi/lo        upper/lower WIDTH bits of the 2*WIDTH result (held until next done)
//   flag_n, flag_z      sign bit of the result / full result is zero
//
// Optional build macro MUL_EARLY_EXIT_EN: leave SHIFT as soon as the remaining
// multiplier bits are all zero, aligning the partial product in a single shift.

module mul_long_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_signed,
  input  logic             op_acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             flag_n,
  output logic             flag_z
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               acc_en_q, acc_en_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               flag_z_q, flag_z_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] fix_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      acc_en_q <= 1'b0;
      prod_q   <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      acc_en_q <= acc_en_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      flag_z_q <= flag_z_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    acc_en_d = acc_en_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    flag_z_d = flag_z_q;

    // Shift-add step: multiplicand into the upper half, carry kept in bit WIDTH.
    addend  = mplier_q[0] ? mcand_q : {WIDTH{1'b0}};
    add_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    // Sign restore then optional accumulate, both modulo 2^(2*WIDTH).
    fix_val = neg_q ? (~prod_q + 1'b1) : prod_q;
    if (acc_en_q) begin
      fix_val = fix_val + acc_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // Magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
          mcand_d  = (op_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
          mplier_d = (op_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
          neg_d    = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = {acc_hi, acc_lo};
          acc_en_d = op_acc;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        prod_d  = '0;
        cnt_d   = CNT_W'(WIDTH);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // The exit test is made before the step, so the final SHIFT cycle only
        // checks the count; this keeps both builds on the same exit path.
`ifdef MUL_EARLY_EXIT_EN
        if (mplier_q == '0) begin
          prod_d  = prod_q >> cnt_q;
          state_d = S_FIXUP;
        end else begin
`else
        if (cnt_q == '0) begin
          state_d = S_FIXUP;
        end else begin
`endif
          prod_d   = {add_sum, prod_q[WIDTH-1:1]};
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CNT_W'(1);
        end
      end
      S_FIXUP: begin
        prod_d   = fix_val;
        res_d    = fix_val;
        flag_z_d = (fix_val == '0);
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result_hi = res_q[2*WIDTH-1:WIDTH];
  assign result_lo = res_q[WIDTH-1:0];
  assign flag_n    = res_q[2*WIDTH-1];
  assign flag_z    = flag_z_q;

endmodule
